// File: rtl/fetch_inst_queue.sv
// FWFT (pc+4, instruction) queue between fetch and decode; one-cycle push-to-head latency, no bypass.
// Backpressure: in_ready drops when full; outputs hold while out_valid & !out_ready.
module fetch_inst_queue #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [DATA_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc4,
    output logic [DATA_W-1:0] out_inst,
    output logic [AW:0]       count
);

    typedef struct packed {
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] inst;
    } entry_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    entry_t         mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           push, pop;
    logic           wr_en;
    entry_t         head;

    // Handshake flags depend on registered occupancy only.
    assign in_ready  = (cnt_q != FULL);
    assign out_valid = (cnt_q != '0);
    assign count     = cnt_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head     = mem_q[rd_ptr_q];
    assign out_pc4  = out_valid ? head.pc4  : '0;
    assign out_inst = out_valid ? head.inst : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        if (reset || flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
    end

    // Storage is deliberately unreset; out_valid masks stale contents.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= '{pc4: in_pc4, inst: in_inst};
        end
    end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Bench for fetch_inst_queue: directed test-plan steps plus random traffic against a queue model.
module tb_fetch_inst_queue;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int AW     = 2;

    logic              clock = 1'b0;
    logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0] in_pc4, in_inst, out_pc4, out_inst;
    logic [AW:0]       count;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] inst;
    } ent_t;

    ent_t mq[$];
    int   passed = 0;
    int   total  = 0;

    fetch_inst_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc4   (in_pc4),
        .in_inst  (in_inst),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc4  (out_pc4),
        .out_inst (out_inst),
        .count    (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Check outputs against the model mid-cycle, then advance the model across the edge.
    task automatic cycle(input bit do_chk);
        bit   push, pop;
        ent_t e;
        @(negedge clock);
        if (do_chk) begin
            chk("count",     32'(count),     32'(mq.size()));
            chk("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("out_pc4",   out_pc4,  (mq.size() != 0) ? mq[0].pc4  : 32'h0);
            chk("out_inst",  out_inst, (mq.size() != 0) ? mq[0].inst : 32'h0);
        end
        push = in_valid && (mq.size() < DEPTH);
        pop  = out_ready && (mq.size() > 0);
        e.pc4  = in_pc4;
        e.inst = in_inst;
        @(posedge clock);
        if (reset || flush) begin
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc4 = '0; in_inst = '0;
        cycle(0);
        cycle(1);
        reset = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc4", out_pc4, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        cycle(1);

        // Fill to full, then offer a fifth entry that must be refused.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_pc4 = 32'(4 * (k + 1)); in_inst = 32'hA0 + 32'(k);
            cycle(1);
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_pc4 = 32'd20; in_inst = 32'hA4;
        cycle(1);
        in_valid = 1'b0;
        chk("full_hold_count", 32'(count), 32'd4);
        chk("full_head_pc4", out_pc4, 32'd4);
        chk("full_head_inst", out_inst, 32'hA0);

        // Drain in order.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_inst", out_inst, 32'hA0 + 32'(k));
            cycle(1);
        end
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_out_inst", out_inst, 32'd0);

        // Concurrent streaming across the pointer wrap.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            in_pc4 = 32'(4 * k); in_inst = 32'(k);
            cycle(1);
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_pc4", out_pc4, 32'(4 * k));
        end
        in_valid = 1'b0;
        cycle(1);

        // Flush together with a push: the pushed entry must vanish.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_pc4 = 32'h10 + 32'(4 * k); in_inst = 32'hC0 + 32'(k);
            cycle(1);
        end
        flush = 1'b1; in_pc4 = 32'h100; in_inst = 32'hDEAD;
        cycle(1);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_pc4", out_pc4, 32'd0);
        out_ready = 1'b1;
        cycle(1);
        cycle(1);

        // Reset mid-operation with a push pending.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_pc4 = 32'h20 + 32'(4 * k); in_inst = 32'hE0 + 32'(k);
            cycle(1);
        end
        reset = 1'b1; in_pc4 = 32'h30; in_inst = 32'hE2;
        cycle(1);
        reset = 1'b0;
        chk("rstmid_count", 32'(count), 32'd0);
        in_pc4 = 32'h40; in_inst = 32'hBEEF;
        cycle(1);
        in_valid = 1'b0;
        chk("rstmid_count1", 32'(count), 32'd1);
        chk("rstmid_pc4", out_pc4, 32'h40);
        chk("rstmid_inst", out_inst, 32'hBEEF);
        cycle(1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 49) == 0);
            in_pc4    = $urandom;
            in_inst   = $urandom;
            cycle(1);
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Small first-word-fall-through instruction queue directly downstream of the fetch stage, upstream of decode.
- Buffers pairs of (PC+4 value, fetched instruction word) with valid/ready handshakes on both sides, so decode stalls do not force the PC register to stall in the same cycle.
- A flush input discards all buffered entries when a branch or jump (SEL_DIR != 00) redirects fetch.

Parameters:
- DATA_W, 32, width of the PC+4 field and of the instruction field.
- DEPTH, 4, number of entries. Must be a power of two and at least 2.
- AW, log2(DEPTH) = 2, pointer width. Derived; do not override.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discards queue contents at the next edge.
- in_valid  input  1  fetch presents an entry.
- in_ready  output  1  queue can accept an entry this cycle.
- in_pc4  input  DATA_W  PC_4 from the fetch stage.
- in_inst  input  DATA_W  instruction word from instruction memory.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode consumes the head entry.
- out_pc4  output  DATA_W  head PC+4 value.
- out_inst  output  DATA_W  head instruction word.
- count  output  AW+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage: circular buffer with write pointer wr_ptr, read pointer rd_ptr (both AW bits) and occupancy register cnt (AW+1 bits).
  - Pointers wrap modulo DEPTH.
  - Storage array is not reset.
- Derived signals:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
  - in_ready = (cnt != DEPTH)
  - out_valid = (cnt != 0)
  - count = cnt
  - All are combinational from registered state only. No combinational path exists from in_valid to in_ready, or from out_ready to out_valid.
- Outputs:
  - out_pc4 and out_inst show the entry at rd_ptr when out_valid = 1.
  - When out_valid = 0 they are forced to 0.
- Latency: an entry pushed at edge N is visible at the outputs after edge N (one cycle). There is no same-cycle bypass when the queue is empty.
- Edge update priority:
  - reset = 1: wr_ptr = rd_ptr = cnt = 0. Other inputs are ignored.
  - else flush = 1: wr_ptr = rd_ptr = cnt = 0. Any push or pop in that cycle is discarded, and no entry is written.
  - else:
    - On push, write the entry at wr_ptr and increment wr_ptr.
    - On pop, increment rd_ptr.
    - cnt += push - pop. Simultaneous push and pop leaves cnt unchanged.
- Reset values after reset: in_ready = 1, out_valid = 0, out_pc4 = 0, out_inst = 0, count = 0.
- Boundary conditions:
  - Full (cnt = DEPTH): in_ready = 0. in_valid is ignored, and the upstream must hold its data.
  - Simultaneous push and pop when full: push is not accepted (in_ready already 0); pop proceeds, and in_ready rises the following cycle.
  - Empty: out_valid = 0, so out_ready is ignored. A push into an empty queue gives cnt = 1 and out_valid = 1 next cycle.
  - Pointer wrap: both pointers roll from DEPTH-1 to 0. Ordering is strictly FIFO across the wrap.
  - Reset or flush mid-stream: all entries are lost. Stale storage contents must never reappear at the outputs.
- Handshake rule: when out_valid = 1 and out_ready = 0, out_pc4 and out_inst stay stable until a pop, flush or reset occurs.

Test Plan:
- Reset then idle: assert reset for 2 cycles -> count = 0, in_ready = 1, out_valid = 0, out_pc4 = out_inst = 0.
- Fill to full: out_ready = 0; push (4, 0xA0), (8, 0xA1), (12, 0xA2), (16, 0xA3) on consecutive cycles -> count = 4, in_ready = 0, out_pc4 = 4, out_inst = 0xA0. A fifth push of (20, 0xA4) while full is not accepted; count stays 4.
- Drain order: from the full state, out_ready = 1 for 4 cycles -> out_inst sequence 0xA0, 0xA1, 0xA2, 0xA3, then out_valid = 0 and outputs 0.
- Concurrent streaming with wrap: in_valid = out_ready = 1 for 10 cycles with in_pc4 = 4*k -> count holds at 1 after the first cycle, and out_pc4 emerges one cycle behind input in order 4, 8, 12, ... across the pointer wrap.
- Flush with simultaneous push: queue holds 3 entries; in the same cycle assert flush = 1 and in_valid = 1 (pc4 = 0x100) -> next cycle count = 0, out_valid = 0, and 0x100 never appears at the outputs.
- Reset mid-operation: with 2 entries held and a push pending, assert reset = 1 together with in_valid = 1 -> count = 0 next cycle. A subsequent push of (0x40, 0xBEEF) appears alone at the head.
